// File: rtl/clint_lite_pkg.sv
// Shared definitions for clint_lite: bus register offsets, mcause codes and FSM states.
package clint_lite_pkg;

  localparam logic [4:0] OFF_MSIP    = 5'h00;
  localparam logic [4:0] OFF_CMP_LO  = 5'h04;
  localparam logic [4:0] OFF_CMP_HI  = 5'h08;
  localparam logic [4:0] OFF_TIME_LO = 5'h0C;
  localparam logic [4:0] OFF_TIME_HI = 5'h10;

  localparam logic [5:0] CAUSE_MSI = 6'd3;
  localparam logic [5:0] CAUSE_MTI = 6'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SERVED = 2'd2
  } state_e;

endpackage

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime with bus write override and a registered mtime >= mtimecmp compare.
module clint_timer
  import clint_lite_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime,
  output logic        mtip
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          mtip_q;
  logic          tick;

  assign tick = (presc_q == PW'(PRESCALE - 1));

  // A bus write replaces the whole increment for that cycle; the prescaler is untouched.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = mtime_q;
    if (wr_lo) begin
      mtime_d = {mtime_q[63:32], wdata};
    end else if (wr_hi) begin
      mtime_d = {wdata, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      mtime_q <= '0;
      mtip_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      mtip_q  <= (mtime_q >= mtimecmp);
    end
  end

  assign mtime = mtime_q;
  assign mtip  = mtip_q;

endmodule

// File: rtl/clint_lite.sv
// Machine timer/software interrupt source with level request and ack/withdraw handshake.
// Define CLINT_SW_IRQ_EN to implement msip (cause 3); otherwise only timer cause 7 exists.
module clint_lite
  import clint_lite_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned BASE_SEL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        mie,
  input  logic        int_ack,
  output logic        interrupt,
  output logic [5:0]  int_cause
);

  // Region decode lives outside; BASE_SEL only records which region that is.
  if (BASE_SEL != 0) begin : g_base_doc
  end

  logic        wr, rd, wr_time_lo, wr_time_hi;
  logic [63:0] mtimecmp_q, mtimecmp_d, mtime;
  logic [31:0] rdata_q, rdata_d, shadow_q, shadow_d;
  logic        mtip, msip, src_pending;
  state_e      state_q, state_d;
  logic [5:0]  cause_q, cause_d;

  assign wr         = sel & mem_w;
  assign rd         = sel & mem_r;
  assign wr_time_lo = wr & (addr == OFF_TIME_LO);
  assign wr_time_hi = wr & (addr == OFF_TIME_HI);

  clint_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_lo   (wr_time_lo),
    .wr_hi   (wr_time_hi),
    .wdata   (wdata),
    .mtimecmp(mtimecmp_q),
    .mtime   (mtime),
    .mtip    (mtip)
  );

`ifdef CLINT_SW_IRQ_EN
  logic msip_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip_q <= 1'b0;
    end else if (wr && (addr == OFF_MSIP)) begin
      msip_q <= wdata[0];
    end
  end
  assign msip = msip_q;
`else
  assign msip = 1'b0;
`endif

  // Reading time_lo snapshots the high word so a following time_hi read cannot tear.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    rdata_d    = rdata_q;
    shadow_d   = shadow_q;
    if (wr && (addr == OFF_CMP_LO)) mtimecmp_d[31:0]  = wdata;
    if (wr && (addr == OFF_CMP_HI)) mtimecmp_d[63:32] = wdata;
    if (rd) begin
      case (addr)
        OFF_MSIP:    rdata_d = {31'b0, msip};
        OFF_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        OFF_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        OFF_TIME_LO: begin
          rdata_d  = mtime[31:0];
          shadow_d = mtime[63:32];
        end
        OFF_TIME_HI: rdata_d = shadow_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  assign src_pending = (cause_q == CAUSE_MSI) ? msip : mtip;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (mie && (msip || mtip)) begin
          state_d = REQ;
          cause_d = msip ? CAUSE_MSI : CAUSE_MTI;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVED;
        end else if (!mie || !src_pending) begin
          state_d = IDLE;
        end
      end
      SERVED: begin
        if (!src_pending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp_q <= '1;
      rdata_q    <= '0;
      shadow_q   <= '0;
      state_q    <= IDLE;
      cause_q    <= '0;
    end else begin
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      shadow_q   <= shadow_d;
      state_q    <= state_d;
      cause_q    <= cause_d;
    end
  end

  assign rdata     = rdata_q;
  assign interrupt = (state_q == REQ);
  assign int_cause = cause_q;

endmodule

// File: tb/tb_clint_lite.sv
// Directed self-checking bench for clint_lite (PRESCALE=1), default and CLINT_SW_IRQ_EN builds.
module tb_clint_lite;

  localparam logic [4:0] A_MSIP    = 5'h00;
  localparam logic [4:0] A_CMP_LO  = 5'h04;
  localparam logic [4:0] A_CMP_HI  = 5'h08;
  localparam logic [4:0] A_TIME_LO = 5'h0C;
  localparam logic [4:0] A_TIME_HI = 5'h10;
  localparam logic [4:0] A_UNMAP   = 5'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        mem_w = 1'b0;
  logic        mem_r = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        mie = 1'b0;
  logic        int_ack = 1'b0;
  logic        interrupt;
  logic [5:0]  int_cause;

  int checks = 0;
  int passes = 0;

  clint_lite #(
    .PRESCALE(1),
    .BASE_SEL(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .mem_w    (mem_w),
    .mem_r    (mem_r),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .mie      (mie),
    .int_ack  (int_ack),
    .interrupt(interrupt),
    .int_cause(int_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Bus tasks start and end just after a negedge so back-to-back calls hit consecutive edges.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; mem_w = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; mem_w = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    sel = 1'b1; mem_r = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; mem_r = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (interrupt !== 1'b0) $display("FAIL reset_irq: got %0b want 0", interrupt);
    else passes++;
    checks++; if (int_cause !== 6'd0) $display("FAIL reset_cause: got %0d want 0", int_cause);
    else passes++;
    checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rdata);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    bus_read(A_CMP_LO, d);
    checks++; if (d !== 32'hFFFF_FFFF) $display("FAIL reset_cmp_lo: got %h want ffffffff", d);
    else passes++;
    bus_read(A_MSIP, d);
    checks++; if (d !== 32'd0) $display("FAIL reset_msip: got %h want 0", d);
    else passes++;
  endtask

  task automatic test_timer();
    mie = 1'b1;
    bus_write(A_TIME_LO, 32'd0);
    bus_write(A_CMP_HI, 32'd0);
    bus_write(A_CMP_LO, 32'd20);
    // mtime reaches 20 on the 18th edge; mtip one edge later, request one edge after that.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 19) begin
        checks++;
        if (interrupt !== 1'b0) $display("FAIL timer_early: got %0b want 0", interrupt);
        else passes++;
      end
      if (i == 20) begin
        checks++;
        if (interrupt !== 1'b1) $display("FAIL timer_irq: got %0b want 1", interrupt);
        else passes++;
        checks++;
        if (int_cause !== 6'd7) $display("FAIL timer_cause: got %0d want 7", int_cause);
        else passes++;
      end
    end
  endtask

  task automatic test_handshake();
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    checks++; if (interrupt !== 1'b0) $display("FAIL ack_drop: got %0b want 0", interrupt);
    else passes++;
    repeat (3) @(negedge clk);
    checks++; if (interrupt !== 1'b0) $display("FAIL served_hold: got %0b want 0", interrupt);
    else passes++;
    bus_write(A_CMP_LO, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    checks++; if (interrupt !== 1'b0) $display("FAIL served_clear: got %0b want 0", interrupt);
    else passes++;
  endtask

  task automatic test_withdraw();
    bus_write(A_CMP_LO, 32'd0);
    @(negedge clk);
    checks++; if (interrupt !== 1'b0) $display("FAIL wd_latency: got %0b want 0", interrupt);
    else passes++;
    @(negedge clk);
    checks++; if (interrupt !== 1'b1) $display("FAIL wd_raise: got %0b want 1", interrupt);
    else passes++;
    mie = 1'b0;
    @(negedge clk);
    checks++; if (interrupt !== 1'b0) $display("FAIL wd_drop: got %0b want 0", interrupt);
    else passes++;
    repeat (2) @(negedge clk);
    mie = 1'b1;
    @(negedge clk);
    checks++; if (interrupt !== 1'b1) $display("FAIL wd_reraise: got %0b want 1", interrupt);
    else passes++;
    int_ack = 1'b1; mie = 1'b0;
    @(negedge clk);
    int_ack = 1'b0; mie = 1'b1;
    checks++; if (interrupt !== 1'b0) $display("FAIL ackwd_drop: got %0b want 0", interrupt);
    else passes++;
    repeat (3) @(negedge clk);
    checks++; if (interrupt !== 1'b0) $display("FAIL ackwd_served: got %0b want 0", interrupt);
    else passes++;
    bus_write(A_CMP_LO, 32'hFFFF_FFFF);
    mie = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tear_free();
    logic [31:0] d;
    bus_write(A_CMP_HI, 32'hFFFF_FFFF);
    bus_read(A_CMP_HI, d);
    checks++; if (d !== 32'hFFFF_FFFF) $display("FAIL cmp_hi_rd: got %h want ffffffff", d);
    else passes++;
    bus_write(A_TIME_HI, 32'd0);
    bus_write(A_TIME_LO, 32'hFFFF_FFFF);
    bus_read(A_TIME_LO, d);
    checks++; if (d !== 32'hFFFF_FFFF) $display("FAIL tear_lo: got %h want ffffffff", d);
    else passes++;
    bus_read(A_TIME_HI, d);
    checks++; if (d !== 32'd0) $display("FAIL tear_hi: got %h want 0", d);
    else passes++;
    bus_read(A_TIME_LO, d);
    checks++; if (d !== 32'd1) $display("FAIL roll_lo: got %h want 1", d);
    else passes++;
    bus_read(A_TIME_HI, d);
    checks++; if (d !== 32'd1) $display("FAIL roll_hi: got %h want 1", d);
    else passes++;
    bus_read(A_UNMAP, d);
    checks++; if (d !== 32'd0) $display("FAIL unmapped_rd: got %h want 0", d);
    else passes++;
  endtask

  task automatic test_sw_irq();
    logic [31:0] d;
`ifdef CLINT_SW_IRQ_EN
    bus_write(A_MSIP, 32'd1);
    bus_read(A_MSIP, d);
    checks++; if (d !== 32'd1) $display("FAIL msip_rd: got %h want 1", d);
    else passes++;
    bus_write(A_CMP_HI, 32'd0);
    repeat (2) @(negedge clk);
    mie = 1'b1;
    @(negedge clk);
    checks++; if (interrupt !== 1'b1) $display("FAIL prio_irq: got %0b want 1", interrupt);
    else passes++;
    checks++; if (int_cause !== 6'd3) $display("FAIL prio_cause: got %0d want 3", int_cause);
    else passes++;
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    bus_write(A_MSIP, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (int_cause !== 6'd7) $display("FAIL msip_clear_cause: got %0d want 7", int_cause);
    else passes++;
    mie = 1'b0;
    @(negedge clk);
`else
    mie = 1'b1;
    bus_write(A_MSIP, 32'd1);
    bus_read(A_MSIP, d);
    checks++; if (d !== 32'd0) $display("FAIL msip_rd: got %h want 0", d);
    else passes++;
    repeat (3) @(negedge clk);
    checks++; if (interrupt !== 1'b0) $display("FAIL msip_noirq: got %0b want 0", interrupt);
    else passes++;
    mie = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] d;
    bus_write(A_MSIP, 32'd0);
    bus_write(A_CMP_HI, 32'd0);
    bus_write(A_CMP_LO, 32'd0);
    repeat (2) @(negedge clk);
    mie = 1'b1;
    @(negedge clk);
    checks++; if (interrupt !== 1'b1) $display("FAIL pre_rst_irq: got %0b want 1", interrupt);
    else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if (interrupt !== 1'b0) $display("FAIL rst_async_irq: got %0b want 0", interrupt);
    else passes++;
    checks++; if (int_cause !== 6'd0) $display("FAIL rst_async_cause: got %0d want 0", int_cause);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    mie = 1'b0;
    bus_read(A_CMP_LO, d);
    checks++; if (d !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_lo: got %h want ffffffff", d);
    else passes++;
    bus_read(A_CMP_HI, d);
    checks++; if (d !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_hi: got %h want ffffffff", d);
    else passes++;
    bus_read(A_TIME_HI, d);
    checks++; if (d !== 32'd0) $display("FAIL rst_shadow: got %h want 0", d);
    else passes++;
    bus_read(A_TIME_LO, d);
    checks++; if (d !== 32'd3) $display("FAIL rst_time_lo: got %h want 3", d);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_handshake();
    test_withdraw();
    test_tear_free();
    test_sw_irq();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
